// File: rtl/ramb18_stream_reader.sv
// ramb18_stream_reader
//   Read-side controller for the ramb18_sdp weight memory. It sweeps the address
//   window [START_ADDR, END_ADDR] cyclically, tracks the two-stage memory read
//   pipeline and presents the words as an AXI-Stream master. A small output FIFO
//   absorbs the pipeline latency, and reads are only issued when a FIFO slot is
//   guaranteed for them, so backpressure never loses or duplicates a word.
//
// Ports
//   clk            clock for all logic
//   rst            asynchronous active-high reset
//   rewind         single-cycle pulse: flush pipeline and FIFO, restart at START_ADDR
//   enb            memory read enable
//   enqb           memory output-register enable (enb delayed one cycle)
//   addrb          memory read address (next address to read)
//   rdqb           memory registered read data
//   m_axis_tdata   stream data (FIFO head, zero while not valid)
//   m_axis_tvalid  stream valid (FIFO not empty)
//   m_axis_tready  stream ready
module ramb18_stream_reader #(
  parameter int DWIDTH     = 18,
  parameter int AWIDTH     = 10,
  parameter int START_ADDR = 0,
  parameter int END_ADDR   = 2**AWIDTH - 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rewind,
  output logic              enb,
  output logic              enqb,
  output logic [AWIDTH-1:0] addrb,
  input  logic [DWIDTH-1:0] rdqb,
  output logic [DWIDTH-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  // Occupancy reaches FIFO_DEPTH and the credit sum adds up to two in-flight reads.
  localparam int CW = PW + 2;

  localparam logic [AWIDTH-1:0] START_A = AWIDTH'(START_ADDR);
  localparam logic [AWIDTH-1:0] END_A   = AWIDTH'(END_ADDR);

  logic              v1;
  logic              v2;
  logic [CW-1:0]     occ;
  logic [CW-1:0]     credit_used;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [DWIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic              push;
  logic              pop;

  // v1 is exactly the output-register enable: a read issued last cycle.
  assign enqb = v1;
  assign push = v2;
  assign pop  = m_axis_tvalid && m_axis_tready;

  // Credits use registered counts only; a pop in this cycle is not credited
  // until the next cycle, which keeps enb free of any path from tready.
  assign credit_used = occ + CW'(v1) + CW'(v2);
  assign enb         = !rst && !rewind && (credit_used < CW'(FIFO_DEPTH));

  assign m_axis_tvalid = (occ != '0);
  assign m_axis_tdata  = m_axis_tvalid ? fifo_mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addrb  <= START_A;
      v1     <= 1'b0;
      v2     <= 1'b0;
      occ    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (rewind) begin
      // Words still in the memory pipeline are dropped along with the FIFO.
      addrb  <= START_A;
      v1     <= 1'b0;
      v2     <= 1'b0;
      occ    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      v1 <= enb;
      v2 <= v1;
      if (enb) begin
        addrb <= (addrb == END_A) ? START_A : addrb + AWIDTH'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        occ <= occ + CW'(1);
      end else if (!push && pop) begin
        occ <= occ - CW'(1);
      end
    end
  end

  // Storage needs no reset: the output is gated by tvalid.
  always_ff @(posedge clk) begin
    if (push && !rewind) begin
      fifo_mem[wr_ptr] <= rdqb;
    end
  end

endmodule

// File: tb/tb_ramb18_stream_reader.sv
module tb_ramb18_stream_reader;

  localparam int DW    = 18;
  localparam int AW    = 10;
  localparam int DEPTH = 4;
  localparam int ST0   = 0;
  localparam int EN0   = 7;
  localparam int ST1   = 5;
  localparam int EN1   = 9;

  logic clk = 1'b0;
  logic rst;
  logic rewind;
  logic tready;

  logic          enb0, enqb0, tvalid0;
  logic          enb1, enqb1, tvalid1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] rdq0, rdq1, tdata0, tdata1;
  logic [DW-1:0] lat0, lat1;

  logic [DW-1:0] mem0 [1024];
  logic [DW-1:0] mem1 [1024];

  logic [DW-1:0] q0 [$];
  logic [DW-1:0] q1 [$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ramb18_stream_reader #(
    .DWIDTH(DW), .AWIDTH(AW), .START_ADDR(ST0), .END_ADDR(EN0), .FIFO_DEPTH(DEPTH)
  ) dut0 (
    .clk(clk), .rst(rst), .rewind(rewind), .enb(enb0), .enqb(enqb0), .addrb(addr0),
    .rdqb(rdq0), .m_axis_tdata(tdata0), .m_axis_tvalid(tvalid0), .m_axis_tready(tready)
  );

  ramb18_stream_reader #(
    .DWIDTH(DW), .AWIDTH(AW), .START_ADDR(ST1), .END_ADDR(EN1), .FIFO_DEPTH(DEPTH)
  ) dut1 (
    .clk(clk), .rst(rst), .rewind(rewind), .enb(enb1), .enqb(enqb1), .addrb(addr1),
    .rdqb(rdq1), .m_axis_tdata(tdata1), .m_axis_tvalid(tvalid1), .m_axis_tready(tready)
  );

  // Two-stage ramb18_sdp read port: array read into a latch on enb, then
  // into the output register on enqb.
  always @(posedge clk) begin
    if (enb0) lat0 <= mem0[addr0];
    if (enqb0) rdq0 <= lat0;
    if (enb1) lat1 <= mem1[addr1];
    if (enqb1) rdq1 <= lat1;
  end

  function automatic void chk(input string nm, input int inst, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t got %0d expected %0d", nm, inst, $time, act, expv);
    end
  endfunction

  // Expected stream: k-th beat after a restart is mem[START + k mod N].
  task automatic refill();
    q0.delete();
    q1.delete();
    for (int k = 0; k < 2000; k++) begin
      q0.push_back(mem0[ST0 + k % (EN0 - ST0 + 1)]);
      q1.push_back(mem1[ST1 + k % (EN1 - ST1 + 1)]);
    end
  endtask

  // Reference model state, per instance. The model counts reads and beats:
  // anything issued and not yet delivered is occupancy plus in-flight, and a
  // read issued in cycle t lands in the FIFO for cycle t+3.
  int issued   [2];
  int popped   [2];
  int landed   [2];
  int p1       [2];
  int p2       [2];
  int p3       [2];
  int cyc      [2];
  int exp_addr [2];
  int prev_stall [2];
  int prev_data  [2];

  always @(negedge clk) begin
    logic          e  [2];
    logic          eq [2];
    logic          tv [2];
    logic [AW-1:0] ad [2];
    logic [DW-1:0] td [2];
    int            st [2];
    int            en [2];
    int            occ_m;
    int            out_m;
    logic [DW-1:0] expd;
    e[0] = enb0;   e[1] = enb1;
    eq[0] = enqb0; eq[1] = enqb1;
    tv[0] = tvalid0; tv[1] = tvalid1;
    ad[0] = addr0; ad[1] = addr1;
    td[0] = tdata0; td[1] = tdata1;
    st[0] = ST0; st[1] = ST1;
    en[0] = EN0; en[1] = EN1;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        chk("rst_enb", i, int'(e[i]), 0);
        chk("rst_enqb", i, int'(eq[i]), 0);
        chk("rst_addrb", i, int'(ad[i]), st[i]);
        chk("rst_tvalid", i, int'(tv[i]), 0);
        chk("rst_tdata", i, int'(td[i]), 0);
        issued[i] = 0; popped[i] = 0; landed[i] = 0;
        p1[i] = 0; p2[i] = 0; p3[i] = 0;
        cyc[i] = 0; exp_addr[i] = st[i]; prev_stall[i] = 0;
      end else begin
        landed[i] += p3[i];
        occ_m = landed[i] - popped[i];
        out_m = issued[i] - popped[i];
        chk("occ_bound", i, int'(occ_m <= DEPTH), 1);
        chk("enb", i, int'(e[i]), int'(!rewind && out_m < DEPTH));
        chk("enqb", i, int'(eq[i]), p1[i]);
        chk("tvalid", i, int'(tv[i]), int'(occ_m > 0));
        if (cyc[i] == 3) chk("first_valid", i, int'(tv[i]), 1);
        if (prev_stall[i] != 0) chk("hold_data", i, int'(td[i]), prev_data[i]);
        if (e[i]) begin
          chk("addrb", i, int'(ad[i]), exp_addr[i]);
          issued[i]++;
          exp_addr[i] = (exp_addr[i] == en[i]) ? st[i] : exp_addr[i] + 1;
        end
        if (tv[i] && tready) begin
          if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL beat dut%0d t=%0t got %0d expected none (queue empty)", i, $time, td[i]);
          end else begin
            expd = (i == 0) ? q0.pop_front() : q1.pop_front();
            chk("beat", i, int'(td[i]), int'(expd));
          end
          popped[i]++;
        end
        prev_stall[i] = int'(tv[i] && !tready);
        prev_data[i] = int'(td[i]);
        p3[i] = p2[i]; p2[i] = p1[i]; p1[i] = int'(e[i]);
        if (rewind) begin
          issued[i] = 0; popped[i] = 0; landed[i] = 0;
          p1[i] = 0; p2[i] = 0; p3[i] = 0;
          cyc[i] = 0; exp_addr[i] = st[i]; prev_stall[i] = 0;
        end else begin
          cyc[i]++;
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    rewind = 1'b0;
    tready = 1'b1;
    for (int k = 0; k < 1024; k++) begin
      mem0[k] = DW'(k);
      mem1[k] = DW'($urandom);
    end
    refill();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Free run, then a 20-cycle stall and resume.
    repeat (40) @(posedge clk);
    #1 tready = 1'b0;
    repeat (20) @(posedge clk);
    #1 tready = 1'b1;
    repeat (20) @(posedge clk);

    // Random ready.
    for (int k = 0; k < 1100; k++) begin
      #1 tready = 1'(($urandom_range(0, 1)));
      @(posedge clk);
    end

    // Rewind while addresses 3..5 of dut0 are in flight (addrb already at 6).
    #1 tready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (addr0 == AW'(6)) break;
    end
    rewind = 1'b1;
    @(posedge clk);
    #1 rewind = 1'b0;
    refill();
    repeat (30) @(posedge clk);

    // Restart with the sink stalled, then reset between edges with 3 words buffered.
    #1 tready = 1'b0;
    rewind = 1'b1;
    @(posedge clk);
    #1 rewind = 1'b0;
    refill();
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    refill();
    @(posedge clk);
    #1 rst = 1'b0;
    tready = 1'b1;
    repeat (30) @(posedge clk);

    // Random ready with occasional rewinds.
    for (int k = 0; k < 300; k++) begin
      #1 tready = 1'(($urandom_range(0, 1)));
      rewind = ($urandom_range(0, 39) == 0);
      @(posedge clk);
      if (rewind) begin
        #1 rewind = 1'b0;
        refill();
        @(posedge clk);
      end
    end

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
